// File: rtl/mem_pkg.sv
// Shared memory-access types for the store unit (and a future load unit):
// access-size and store-FSM enums plus an alignment check.
package mem_pkg;

    // Widest byte-offset the alignment helper accepts; callers zero-extend.
    localparam int MAX_OFF_W = 8;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2,
        MEM_RSVD = 2'd3
    } mem_size_t;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MERGE,
        WRITE,
        FAULT
    } store_state_t;

    // True when an access of the given size may start at this byte offset.
    // Reserved size is never aligned, so it always faults when trapping.
    function automatic logic is_aligned(input logic [MAX_OFF_W-1:0] offset,
                                        input mem_size_t size);
        case (size)
            MEM_BYTE: is_aligned = 1'b1;
            MEM_HALF: is_aligned = ~offset[0];
            MEM_WORD: is_aligned = (offset == '0);
            default:  is_aligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational byte-lane merge: overlays right-aligned store data onto an
// existing word at a byte offset (little-endian lanes). Lanes outside the
// store pass the old word through. Needs DATA_WIDTH >= 16.
module store_merge
    import mem_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int OFF_W      = $clog2(DATA_WIDTH / 8),
    localparam int LANES      = DATA_WIDTH / 8
) (
    input  logic [DATA_WIDTH-1:0] i_old,
    input  logic [DATA_WIDTH-1:0] i_new,
    input  logic [OFF_W-1:0]      i_off,
    input  mem_size_t             i_size,
    output logic [DATA_WIDTH-1:0] o_merged
);

    logic sel_word;
    assign sel_word = (i_size == MEM_WORD) || (i_size == MEM_RSVD);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            localparam logic [OFF_W-1:0] LANE = OFF_W'(gi);
            logic sel_lo;
            logic sel_hi;
            // Low byte of the store lands at the offset; a half's high byte
            // lands one lane up (aligned halves never wrap out of the word).
            assign sel_lo = ((i_size == MEM_BYTE) || (i_size == MEM_HALF)) && (i_off == LANE);
            assign sel_hi = (i_size == MEM_HALF) && ((i_off + OFF_W'(1)) == LANE);
            assign o_merged[gi*8 +: 8] = sel_word ? i_new[gi*8 +: 8] :
                                         sel_lo   ? i_new[7:0]       :
                                         sel_hi   ? i_new[15:8]      :
                                                    i_old[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts byte/half/word stores over valid/ready and writes them
// to a synchronous-read BRAM port. Word stores write directly; sub-word
// stores read the word first and merge the new bytes in.
// Optional macro STORE_MISALIGN_TRAP_EN: misaligned or reserved-size stores
// complete through FAULT with o_misaligned and no write. Without it, offsets
// are force-aligned and reserved size behaves as a word store.
module store_unit
    import mem_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 10,
    localparam int OFF_W      = $clog2(DATA_WIDTH / 8)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [ADDR_WIDTH+OFF_W-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [1:0]            i_size,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_data,
    output logic                  o_mem_write,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    output logic                  o_done,
    output logic                  o_misaligned
);

    store_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [OFF_W-1:0]      off_q,   off_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    mem_size_t             size_q,  size_d;

    logic [OFF_W-1:0]      req_off;
    logic [ADDR_WIDTH-1:0] req_word;
    mem_size_t             req_size;
    logic [DATA_WIDTH-1:0] merged;

    assign req_off  = i_addr[OFF_W-1:0];
    assign req_word = i_addr[OFF_W +: ADDR_WIDTH];
    assign req_size = mem_size_t'(i_size);

    // Ready only in IDLE, and held low while reset is asserted.
    assign o_ready    = (state_q == IDLE) && !i_rst;
    assign o_mem_addr = addr_q;

    store_merge #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_merge (
        .i_old   (i_mem_data),
        .i_new   (data_q),
        .i_off   (off_q),
        .i_size  (size_q),
        .o_merged(merged)
    );

    // State and latched request registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            off_q   <= '0;
            data_q  <= '0;
            size_q  <= MEM_BYTE;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            data_q  <= data_d;
            size_q  <= size_d;
        end
    end

    // Next-state, request latching and BRAM/handshake outputs.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        off_d        = off_q;
        data_d       = data_q;
        size_d       = size_q;
        o_mem_data   = '0;
        o_mem_write  = 1'b0;
        o_done       = 1'b0;
        o_misaligned = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    addr_d = req_word;
                    data_d = i_data;
`ifdef STORE_MISALIGN_TRAP_EN
                    off_d  = req_off;
                    size_d = req_size;
                    if (!is_aligned(MAX_OFF_W'(req_off), req_size)) begin
                        state_d = FAULT;
                    end else if (req_size == MEM_WORD) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
`else
                    if ((req_size == MEM_WORD) || (req_size == MEM_RSVD)) begin
                        size_d  = MEM_WORD;
                        off_d   = '0;
                        state_d = WRITE;
                    end else begin
                        size_d  = req_size;
                        off_d   = (req_size == MEM_HALF) ? (req_off & ~OFF_W'(1)) : req_off;
                        state_d = READ;
                    end
`endif
                end
            end
            READ: begin
                state_d = MERGE;
            end
            MERGE: begin
                o_mem_data  = merged;
                o_mem_write = 1'b1;
                o_done      = 1'b1;
                state_d     = IDLE;
            end
            WRITE: begin
                o_mem_data  = data_q;
                o_mem_write = 1'b1;
                o_done      = 1'b1;
                state_d     = IDLE;
            end
`ifdef STORE_MISALIGN_TRAP_EN
            FAULT: begin
                o_done       = 1'b1;
                o_misaligned = 1'b1;
                state_d      = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Memory-write engine for the core: the writer-side counterpart of the instruction fetch reader.
- Accepts byte, half and word store requests from the execute stage over a valid/ready handshake.
- Drives a word-wide, synchronous-read BRAM port. Full-word stores are written directly.
- Sub-word stores use read-modify-write, so neighbouring bytes in the word are preserved.
- Little-endian byte lanes.

Parameters:
- DATA_WIDTH, 32, BRAM word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10, BRAM word-address width.
- OFF_W, $clog2(DATA_WIDTH/8), byte-offset width (derived, not overridden).

Ports:
- i_clk  in  1  single clock; all logic on its rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  store request valid.
- o_ready  out  1  unit can accept a request (high only in IDLE).
- i_addr  in  ADDR_WIDTH+OFF_W  byte address of the store.
- i_data  in  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0]).
- i_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- o_mem_addr  out  ADDR_WIDTH  BRAM word address.
- o_mem_data  out  DATA_WIDTH  BRAM write data.
- o_mem_write  out  1  BRAM write enable.
- i_mem_data  in  DATA_WIDTH  BRAM read data, valid the cycle after the address is presented.
- o_done  out  1  one-cycle pulse when the request completes.
- o_misaligned  out  1  one-cycle pulse together with o_done on a faulted request.

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE; latched addr/data/size cleared.
  - o_mem_addr=0, o_mem_data=0, o_mem_write=0, o_done=0, o_misaligned=0, o_ready=1 once reset is released.
  - o_mem_write is decoded from state, so reset suppresses it immediately. An in-flight request is dropped with no write and no o_done.
- Handshake:
  - Accept on a rising edge with i_valid&&o_ready; request fields are latched then.
  - i_valid held high while o_ready=0 is ignored. No request is queued.
- States and transitions:
  - IDLE: on accept, go to FAULT if misaligned or size=3; WRITE if size=word; otherwise READ.
  - READ: o_mem_addr=latched word address, o_mem_write=0. Next state MERGE.
  - MERGE: combinationally replace the addressed byte lanes of i_mem_data with the latched data. Drive o_mem_data=merged, o_mem_write=1, o_done=1. Next state IDLE.
  - WRITE: o_mem_data=latched data, o_mem_write=1, o_done=1. Next state IDLE.
  - FAULT: o_done=1, o_misaligned=1, o_mem_write=0. Next state IDLE.
- Latency from the accept edge:
  - Word store: write and o_done in the next cycle; 2 cycles to o_ready.
  - Sub-word store: READ, then MERGE; o_done 2 cycles after accept; 3 cycles to o_ready.
  - Fault: o_done in the next cycle.
- Alignment rules:
  - Half requires i_addr[0]=0. Word requires all OFF_W low address bits = 0.
  - A half store never crosses a word boundary.
- Lane merge:
  - Byte: lane = offset.
  - Half: lanes offset and offset+1.
  - Unselected lanes pass i_mem_data through unchanged.
- Boundaries:
  - Highest word address: no wrap logic; o_mem_addr is truncated to ADDR_WIDTH.
  - Back-to-back requests: the next accept happens in the first cycle IDLE is re-entered (o_ready=1).

Optional Feature:
- Macro: STORE_MISALIGN_TRAP_EN.
- Defined: misaligned or reserved-size requests go to FAULT as described above; memory is untouched.
- Undefined:
  - No FAULT state; o_misaligned is tied 0.
  - Half offset has bit 0 cleared; word offset is forced to 0. The store then proceeds normally.
  - Size 3 is treated as word.

Decomposition:
- Shared package `mem_pkg`:
  - mem_size_t enum: MEM_BYTE=2'd0, MEM_HALF=2'd1, MEM_WORD=2'd2, MEM_RSVD=2'd3.
  - store_state_t enum: IDLE, READ, MERGE, WRITE, FAULT.
  - Alignment-check function, reusable by a future load unit.
- Sub-module `store_merge`: purely combinational (old word, new data, offset, size) -> merged word. It is reusable for a store buffer later.

Test Plan:
- Memory preload: word 5 = 0x11223344.
- Byte store 0xAB to byte address 0x15: read at T1, write at T2 with o_mem_data=0x1122AB44, o_done at T2, o_ready at T3.
- Half store 0xBEEF to 0x16 -> word 5 = 0xBEEF3344; bytes 0x14/0x15 unchanged.
- Word store 0xDEADBEEF to 0x14: o_mem_write=1 at T1 with no READ cycle; word 5 = 0xDEADBEEF.
- Half store to 0x15:
  - With macro: o_done=o_misaligned=1 at T1, no write, word 5 unchanged.
  - Without macro: writes at 0x14 -> low half replaced.
- Reset pulse during READ of a byte store: o_mem_write never asserted, no o_done, word 5 unchanged, o_ready=1 after release.
- i_valid held high with two queued requests (word, then byte): second accepted at T2 only; both writes land in order.
